// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider datapath.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

  function automatic int unsigned div_cnt_w(int unsigned xlen);
    return $clog2(xlen + 1);
  endfunction

  // Sliced down to the operand width by the user.
  localparam logic [63:0] DIV_ERR_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract divisor, restore on borrow.
module div_step #(
  parameter int unsigned XLEN = 5
) (
  input  logic [XLEN:0]   r,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   r_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0]   r_sh;
  logic [XLEN+1:0] t;
  logic            neg;

  always_comb begin
    r_sh = {r[XLEN-1:0], q[XLEN-1]};
    // One extra bit so the borrow out of the XLEN+1-bit subtract is visible.
    t      = {r, q[XLEN-1]} - {2'b00, divisor};
    neg    = t[XLEN+1];
    r_next = neg ? r_sh : t[XLEN:0];
    q_next = {q[XLEN-2:0], ~neg};
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider: 2*XLEN / XLEN -> XLEN quotient and remainder, one bit per clock.
module restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*XLEN-1:0] dividend,
  input  logic [XLEN-1:0]   divisor,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder,
  output logic              div_by_zero,
  output logic              overflow
);

  localparam int unsigned CW = div_cnt_w(XLEN);

  div_state_e      state, nstate;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   r, r_nx;
  logic [XLEN-1:0] q, q_nx, dvsr;
  logic            dz, ovf, last;

  always_comb begin
    dz   = (divisor == '0);
    ovf  = (dividend[2*XLEN-1:XLEN] >= divisor);
    last = (cnt == CW'(XLEN - 1));
  end

  div_step #(.XLEN(XLEN)) u_step (
    .r       (r),
    .q       (q),
    .divisor (dvsr),
    .r_next  (r_nx),
    .q_next  (q_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = (dz || ovf) ? DONE : CALC;
      CALC:    if (last) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Result registers are written on the edge that enters DONE, so done and data appear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dvsr <= divisor;
            if (dz) begin
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              quotient    <= DIV_ERR_QUOT[XLEN-1:0];
              remainder   <= '0;
            end else if (ovf) begin
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              quotient    <= DIV_ERR_QUOT[XLEN-1:0];
              remainder   <= '0;
            end else begin
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
              r           <= {1'b0, dividend[2*XLEN-1:XLEN]};
              q           <= dividend[XLEN-1:0];
              cnt         <= '0;
            end
          end
        end
        CALC: begin
          r   <= r_nx;
          q   <= q_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            quotient  <= q_nx;
            remainder <= r_nx[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
